// File: rtl/decode_instruction_queue.sv
// Purpose: in-order instruction queue between predecode and the format decoders; tags each entry with a major ID at enqueue.
// Latency: one cycle from push edge to issue edge (no bypass); the issue bundle is fully registered.
// Backpressure: stall_i keeps the head queued (enable_o drops next edge); pushes into a full queue are dropped unless a pop frees a slot on the same edge.
module decode_instruction_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int opcodeSize              = 6,
  parameter int formatWidth             = 26,
  parameter int queueDepth              = 8,
  parameter int countWidth              = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               enable_i,
  input  logic [formatWidth-1:0]             instFormat_i,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               stall_i,
  output logic                               full_o,
  output logic [countWidth-1:0]              count_o,
  output logic                               enable_o,
  output logic [formatWidth-1:0]             instFormat_o,
  output logic [opcodeSize-1:0]              instructionOpcode_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
);

  localparam int ptrWidth = $clog2(queueDepth);
  localparam logic [countWidth-1:0] fullCount = countWidth'(queueDepth);

  // Entry storage, one array per field of the decoder bundle
  logic [formatWidth-1:0]             formatMem  [queueDepth];
  logic [instructionWidth-1:0]        instMem    [queueDepth];
  logic [addressWidth-1:0]            addrMem    [queueDepth];
  logic                               is64Mem    [queueDepth];
  logic [PidSize-1:0]                 pidMem     [queueDepth];
  logic [TidSize-1:0]                 tidMem     [queueDepth];
  logic [instructionCounterWidth-1:0] majIdMem   [queueDepth];

  logic [ptrWidth-1:0]                readPtr;
  logic [ptrWidth-1:0]                writePtr;
  logic [countWidth-1:0]              count;
  logic [instructionCounterWidth-1:0] majIdCounter;

  logic isFull;
  logic doPop;
  logic doPush;

  // Pop decisions use occupancy before the edge, so a freshly pushed entry never bypasses.
  // A full queue still accepts a push when the head leaves on the same edge.
  assign isFull = (count == fullCount);
  assign doPop  = !flush_i && !stall_i && (count != '0);
  assign doPush = !flush_i && enable_i && (!isFull || doPop);

  assign full_o  = isFull;
  assign count_o = count;

  // Opcode is bits 0..5 in big-endian numbering, i.e. the most significant bits of the word
  assign instructionOpcode_o = instruction_o[instructionWidth-1 -: opcodeSize];

  // Write the accepted instruction and its major ID at the tail
  always_ff @(posedge clock_i) begin
    if (doPush) begin
      formatMem[writePtr] <= instFormat_i;
      instMem[writePtr]   <= instruction_i;
      addrMem[writePtr]   <= instructionAddress_i;
      is64Mem[writePtr]   <= is64Bit_i;
      pidMem[writePtr]    <= instructionPid_i;
      tidMem[writePtr]    <= instructionTid_i;
      majIdMem[writePtr]  <= majIdCounter;
    end
  end

  // Pointer, occupancy and major ID bookkeeping; flush empties the queue but keeps IDs unique
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      readPtr      <= '0;
      writePtr     <= '0;
      count        <= '0;
      majIdCounter <= '0;
    end else if (flush_i) begin
      readPtr  <= '0;
      writePtr <= '0;
      count    <= '0;
    end else begin
      if (doPush) begin
        writePtr     <= writePtr + 1'b1;
        majIdCounter <= majIdCounter + 1'b1;
      end
      if (doPop) begin
        readPtr <= readPtr + 1'b1;
      end
      if (doPush && !doPop) begin
        count <= count + 1'b1;
      end else if (doPop && !doPush) begin
        count <= count - 1'b1;
      end
    end
  end

  // Registered issue bundle; data holds its last value when nothing is issued
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      enable_o             <= 1'b0;
      instFormat_o         <= '0;
      instruction_o        <= '0;
      instructionAddress_o <= '0;
      is64Bit_o            <= 1'b0;
      instructionPid_o     <= '0;
      instructionTid_o     <= '0;
      instructionMajId_o   <= '0;
    end else begin
      enable_o <= doPop;
      if (doPop) begin
        instFormat_o         <= formatMem[readPtr];
        instruction_o        <= instMem[readPtr];
        instructionAddress_o <= addrMem[readPtr];
        is64Bit_o            <= is64Mem[readPtr];
        instructionPid_o     <= pidMem[readPtr];
        instructionTid_o     <= tidMem[readPtr];
        instructionMajId_o   <= majIdMem[readPtr];
      end
    end
  end

endmodule
